// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - shared types and default geometry for the HUB75 column shifter
package hub75_pkg;

  localparam int def_hpixel   = 64;
  localparam int def_vpixel   = 64;
  localparam int def_bpp      = 8;
  localparam int def_segments = 2;
  localparam int out_rows     = def_vpixel / def_segments;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    CLK_LO,
    CLK_HI,
    LATCH,
    DONE
  } shifter_state_t;

  // One segment's slice of a framebuffer word; r sits in the LSBs.
  typedef struct packed {
    logic [def_bpp-1:0] b;
    logic [def_bpp-1:0] g;
    logic [def_bpp-1:0] r;
  } pixel_t;

endpackage

// File: rtl/hub75_shifter_if.sv
// rtl/hub75_shifter_if.sv - framebuffer read port between the shifter and the pixel RAM
interface hub75_shifter_if #(
  parameter int addr_w_p = 11,
  parameter int data_w_p = 48
);
  logic                fb_rd;
  logic [addr_w_p-1:0] fb_addr;
  logic [data_w_p-1:0] fb_data;

  modport master (output fb_rd, output fb_addr, input fb_data);
  modport slave  (input fb_rd, input fb_addr, output fb_data);
endinterface

// File: rtl/hub75_bit_extract.sv
// rtl/hub75_bit_extract.sv - picks one bit-plane out of every channel of every segment
module hub75_bit_extract #(
  parameter int bpp_p      = 8,
  parameter int segments_p = 2
) (
  input  logic [segments_p*3*bpp_p-1:0] pixel_i,
  input  logic [$clog2(bpp_p)-1:0]      pix_bit_i,
  output logic [3*segments_p-1:0]       rgb_o
);

  logic [bpp_p-1:0] chan;

  always_comb begin
    rgb_o = '0;
    chan  = '0;
    for (int s = 0; s < segments_p; s++) begin
      for (int c = 0; c < 3; c++) begin
        chan             = pixel_i[(s*3+c)*bpp_p +: bpp_p];
        rgb_o[s*3 + c]   = chan[pix_bit_i];
      end
    end
  end

endmodule

// File: rtl/hub75_shifter.sv
// rtl/hub75_shifter.sv - shifts one bit-plane of a row pair into the panel, then latches it
module hub75_shifter
  import hub75_pkg::*;
#(
  parameter int hpixel_p    = def_hpixel,
  parameter int vpixel_p    = def_vpixel,
  parameter int bpp_p       = def_bpp,
  parameter int segments_p  = def_segments,
  parameter int clk_div_p   = 2,
  parameter int latch_len_p = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    i_start,
  input  logic [$clog2(vpixel_p/segments_p)-1:0]  i_row,
  input  logic [$clog2(bpp_p)-1:0]                i_pix_bit,
  hub75_shifter_if.master                         fb,
  output logic [3*segments_p-1:0]                 o_rgb,
  output logic                                    o_hub_clk,
  output logic                                    o_latch,
  output logic                                    o_busy,
  output logic                                    o_done
);

  localparam int rows_lp   = vpixel_p / segments_p;
  localparam int row_w_lp  = $clog2(rows_lp);
  localparam int col_w_lp  = $clog2(hpixel_p);
  localparam int bit_w_lp  = $clog2(bpp_p);
  localparam int addr_w_lp = $clog2(hpixel_p * rows_lp);
  localparam int data_w_lp = segments_p * 3 * bpp_p;
  localparam int ph_max_lp = (clk_div_p > latch_len_p) ? clk_div_p : latch_len_p;
  localparam int ph_w_lp   = $clog2(ph_max_lp) + 1;

  shifter_state_t       state_q, state_d;
  logic [row_w_lp-1:0]  row_q, row_d;
  logic [bit_w_lp-1:0]  bit_q, bit_d;
  logic [col_w_lp-1:0]  col_q, col_d;
  logic [ph_w_lp-1:0]   phase_q, phase_d;
  logic [data_w_lp-1:0] pix_q, pix_d;
  logic [3*segments_p-1:0] rgb_bits;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      bit_q   <= '0;
      col_q   <= '0;
      phase_q <= '0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      bit_q   <= bit_d;
      col_q   <= col_d;
      phase_q <= phase_d;
      pix_q   <= pix_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    bit_d   = bit_q;
    col_d   = col_q;
    phase_d = phase_q;
    pix_d   = pix_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          row_d   = i_row;
          bit_d   = i_pix_bit;
          col_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: state_d = WAIT;
      WAIT: begin
        pix_d   = fb.fb_data;
        phase_d = '0;
        state_d = CLK_LO;
      end
      CLK_LO: begin
        if (phase_q == ph_w_lp'(clk_div_p - 1)) begin
          phase_d = '0;
          state_d = CLK_HI;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      CLK_HI: begin
        if (phase_q == ph_w_lp'(clk_div_p - 1)) begin
          phase_d = '0;
          if (col_q == col_w_lp'(hpixel_p - 1)) begin
            state_d = LATCH;
          end else begin
            col_d   = col_q + 1'b1;
            state_d = FETCH;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      LATCH: begin
        if (phase_q == ph_w_lp'(latch_len_p - 1)) begin
          phase_d = '0;
          state_d = DONE;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  hub75_bit_extract #(
    .bpp_p      (bpp_p),
    .segments_p (segments_p)
  ) u_extract (
    .pixel_i   (pix_q),
    .pix_bit_i (bit_q),
    .rgb_o     (rgb_bits)
  );

  // Panel data is only driven while a column is on the wire or being latched.
  assign o_rgb      = (state_q inside {CLK_LO, CLK_HI, LATCH}) ? rgb_bits : '0;
  assign fb.fb_rd   = (state_q == FETCH);
  assign fb.fb_addr = (state_q == FETCH)
                    ? addr_w_lp'(addr_w_lp'(row_q) * addr_w_lp'(hpixel_p) + addr_w_lp'(col_q))
                    : '0;
  assign o_hub_clk  = (state_q == CLK_HI);
  assign o_latch    = (state_q == LATCH);
  assign o_busy     = (state_q != IDLE);
  assign o_done     = (state_q == DONE);

endmodule

// File: tb/tb_hub75_shifter.sv
// tb/tb_hub75_shifter.sv - self-checking bench for hub75_shifter against a cycle-trace model
module tb_hub75_shifter;
  import hub75_pkg::*;

  localparam int H    = 4;
  localparam int V    = 64;
  localparam int BPP  = 8;
  localparam int SEG  = 2;
  localparam int CD   = 1;
  localparam int LL   = 2;
  localparam int ROWS = V / SEG;
  localparam int RW   = $clog2(ROWS);
  localparam int BW   = $clog2(BPP);
  localparam int AW   = $clog2(H * ROWS);
  localparam int DW   = SEG * 3 * BPP;
  localparam int CW   = 3 * SEG;

  typedef struct {
    logic          rd;
    logic [AW-1:0] addr;
    logic [CW-1:0] rgb;
    bit            rgb_care;
    logic          hclk;
    logic          latch;
    logic          busy;
    logic          done;
  } exp_t;

  logic          clk = 0;
  logic          tb_rst = 1;
  logic          tb_start = 0;
  logic [RW-1:0] tb_row = '0;
  logic [BW-1:0] tb_bit = '0;
  logic [CW-1:0] o_rgb;
  logic          o_hub_clk, o_latch, o_busy, o_done;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  exp_t          exp_q[$];
  int            fetch_q[$];
  logic [CW-1:0] first_lo_rgb;
  int            busy_cnt;
  int            checks = 0;
  int            passes = 0;

  hub75_shifter_if #(.addr_w_p(AW), .data_w_p(DW)) fb_if ();

  hub75_shifter #(
    .hpixel_p(H), .vpixel_p(V), .bpp_p(BPP), .segments_p(SEG),
    .clk_div_p(CD), .latch_len_p(LL)
  ) dut (
    .clk       (clk),
    .rst       (tb_rst),
    .i_start   (tb_start),
    .i_row     (tb_row),
    .i_pix_bit (tb_bit),
    .fb        (fb_if),
    .o_rgb     (o_rgb),
    .o_hub_clk (o_hub_clk),
    .o_latch   (o_latch),
    .o_busy    (o_busy),
    .o_done    (o_done)
  );

  always #5 clk = ~clk;

  // RAM model: data valid one cycle after the read strobe, junk otherwise.
  always @(posedge clk) begin
    if (fb_if.fb_rd) fb_if.fb_data <= mem[fb_if.fb_addr];
    else             fb_if.fb_data <= DW'({$urandom(), $urandom()});
  end

  function automatic logic [CW-1:0] model_rgb(input logic [DW-1:0] w, input int pb);
    pixel_t        p;
    logic [CW-1:0] r;
    for (int s = 0; s < SEG; s++) begin
      p          = w[s*$bits(pixel_t) +: $bits(pixel_t)];
      r[3*s]     = p.r[pb];
      r[3*s + 1] = p.g[pb];
      r[3*s + 2] = p.b[pb];
    end
    return r;
  endfunction

  function automatic exp_t mk(input logic rd, input int addr, input logic [CW-1:0] rgb,
                              input bit care, input logic hclk, input logic latch, input logic done);
    exp_t e;
    e.rd = rd; e.addr = AW'(addr); e.rgb = rgb; e.rgb_care = care;
    e.hclk = hclk; e.latch = latch; e.busy = 1'b1; e.done = done;
    return e;
  endfunction

  function automatic void build_trace(input int row, input int pb);
    logic [CW-1:0] px;
    px = '0;
    exp_q.delete();
    for (int col = 0; col < H; col++) begin
      exp_q.push_back(mk(1, row*H + col, '0, 0, 0, 0, 0));
      exp_q.push_back(mk(0, 0, '0, 0, 0, 0, 0));
      px = model_rgb(mem[row*H + col], pb);
      for (int k = 0; k < CD; k++) exp_q.push_back(mk(0, 0, px, 1, 0, 0, 0));
      for (int k = 0; k < CD; k++) exp_q.push_back(mk(0, 0, px, 1, 1, 0, 0));
    end
    for (int k = 0; k < LL; k++) exp_q.push_back(mk(0, 0, px, 1, 0, 1, 0));
    exp_q.push_back(mk(0, 0, '0, 0, 0, 0, 1));
  endfunction

  task automatic check_idle(input string name);
    checks++;
    if ({fb_if.fb_rd, fb_if.fb_addr, o_rgb, o_hub_clk, o_latch, o_busy, o_done} !== '0)
      $display("FAIL %s: outputs rd=%b addr=%0d rgb=%b hclk=%b latch=%b busy=%b done=%b, required all 0",
               name, fb_if.fb_rd, fb_if.fb_addr, o_rgb, o_hub_clk, o_latch, o_busy, o_done);
    else passes++;
  endtask

  // Runs one load from IDLE and compares every busy cycle with the model trace.
  task automatic run_load(input int row, input int pb, input bit spam, input bit start_at_done,
                          input string name);
    exp_t e;
    logic [11:0] obs, req;
    bit got_lo;
    got_lo = 0;
    busy_cnt = 0;
    fetch_q.delete();
    build_trace(row, pb);
    @(negedge clk);
    tb_start = 1; tb_row = RW'(row); tb_bit = BW'(pb);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      e   = exp_q[i];
      obs = {fb_if.fb_rd, fb_if.fb_addr, o_hub_clk, o_latch, o_busy, o_done};
      req = {e.rd, e.addr, e.hclk, e.latch, e.busy, e.done};
      checks++;
      if (obs !== req) $display("FAIL %s cyc%0d ctrl: got %h required %h", name, i + 1, obs, req);
      else passes++;
      if (e.rgb_care) begin
        checks++;
        if (o_rgb !== e.rgb) $display("FAIL %s cyc%0d rgb: got %b required %b", name, i + 1, o_rgb, e.rgb);
        else passes++;
        if (!got_lo && !e.hclk && !e.latch) begin first_lo_rgb = o_rgb; got_lo = 1; end
      end
      if (o_busy) busy_cnt++;
      if (fb_if.fb_rd) fetch_q.push_back(int'(fb_if.fb_addr));
      if (spam) begin
        tb_start = 1'($urandom_range(0, 1));
        tb_row   = RW'($urandom_range(0, ROWS - 1));
        tb_bit   = BW'($urandom_range(0, BPP - 1));
      end else begin
        tb_start = 0;
      end
      if (start_at_done && i == exp_q.size() - 1) tb_start = 1;
    end
    @(negedge clk);
    check_idle({name, " idle after done"});
    if (!start_at_done) tb_start = 0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'({$urandom(), $urandom()});
  endtask

  task automatic test_reset();
    tb_rst = 1;
    repeat (3) @(negedge clk);
    check_idle("reset");
    tb_rst = 0;
    @(negedge clk);
    check_idle("post reset");
  endtask

  task automatic test_timing();
    run_load(int'($urandom_range(0, ROWS - 1)), int'($urandom_range(0, BPP - 1)), 0, 0, "timing");
    checks++;
    if (busy_cnt !== H*(2 + 2*CD) + LL + 1)
      $display("FAIL timing busy cycles: got %0d required %0d", busy_cnt, H*(2 + 2*CD) + LL + 1);
    else passes++;
  endtask

  task automatic test_pattern();
    pixel_t p;
    p.r = 8'hA5; p.g = 8'h00; p.b = 8'hFF;
    for (int c = 0; c < H; c++) mem[5*H + c] = {p, p};
    run_load(5, 0, 0, 0, "pattern b0");
    checks++;
    if (first_lo_rgb[2:0] !== 3'b101) $display("FAIL pattern b0 rgb: got %b required 101", first_lo_rgb[2:0]);
    else passes++;
    run_load(5, 1, 0, 0, "pattern b1");
    checks++;
    if (first_lo_rgb[2:0] !== 3'b100) $display("FAIL pattern b1 rgb: got %b required 100", first_lo_rgb[2:0]);
    else passes++;
  endtask

  task automatic test_addr();
    int rows_t[2];
    rows_t[0] = 3; rows_t[1] = ROWS - 1;
    for (int r = 0; r < 2; r++) begin
      run_load(rows_t[r], 0, 0, 0, "addr");
      checks++;
      if (fetch_q.size() !== H) $display("FAIL addr count row%0d: got %0d required %0d", rows_t[r], fetch_q.size(), H);
      else passes++;
      for (int i = 0; i < fetch_q.size() && i < H; i++) begin
        checks++;
        if (fetch_q[i] !== rows_t[r]*H + i)
          $display("FAIL addr row%0d fetch%0d: got %0d required %0d", rows_t[r], i, fetch_q[i], rows_t[r]*H + i);
        else passes++;
      end
    end
  endtask

  task automatic test_segment();
    int pb;
    pb = int'($urandom_range(0, BPP - 1));
    for (int c = 0; c < H; c++) mem[7*H + c] = DW'(1) << (3*BPP + BPP + pb);
    run_load(7, pb, 0, 0, "segment");
    checks++;
    if (first_lo_rgb !== 6'b010000) $display("FAIL segment rgb: got %b required 010000", first_lo_rgb);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int nr;
    bit seen_done;
    fill_random();
    run_load(int'($urandom_range(0, ROWS - 1)), int'($urandom_range(0, BPP - 1)), 1, 0, "restart spam");
    nr = int'($urandom_range(0, ROWS - 1));
    run_load(9, 2, 0, 1, "restart at done");
    tb_row = RW'(nr);
    @(negedge clk);
    tb_start = 0;
    checks++;
    if ({o_busy, fb_if.fb_rd, fb_if.fb_addr} !== {1'b1, 1'b1, AW'(nr*H)})
      $display("FAIL restart accept: got busy=%b rd=%b addr=%0d required 1 1 %0d",
               o_busy, fb_if.fb_rd, fb_if.fb_addr, nr*H);
    else passes++;
    seen_done = 0;
    for (int i = 0; i < 100 && !seen_done; i++) begin
      @(negedge clk);
      if (o_done) seen_done = 1;
    end
    checks++;
    if (!seen_done) $display("FAIL restart drain: got no done, required done within 100 cycles");
    else passes++;
    @(negedge clk);
    check_idle("restart drained");
  endtask

  task automatic test_reset_mid();
    int  n_hi;
    bit  found, saw_latch;
    n_hi = 0; found = 0; saw_latch = 0;
    @(negedge clk);
    tb_start = 1; tb_row = RW'($urandom_range(0, ROWS - 1)); tb_bit = '0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      tb_start = 0;
      if (o_latch) saw_latch = 1;
      if (o_hub_clk) n_hi++;
      if (n_hi == 3) found = 1;
    end
    checks++;
    if (!found) $display("FAIL midreset find col2 clk_hi: got %0d hub_clk highs, required 3", n_hi);
    else passes++;
    tb_rst = 1;
    @(negedge clk);
    check_idle("midreset next cycle");
    tb_rst = 0;
    repeat (40) begin
      @(negedge clk);
      if (o_latch || o_busy) saw_latch = 1;
    end
    checks++;
    if (saw_latch) $display("FAIL midreset latch/busy after abort: got 1 required 0");
    else passes++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 3; n++) begin
      fill_random();
      run_load(int'($urandom_range(0, ROWS - 1)), int'($urandom_range(0, BPP - 1)), 0, 0, "random");
    end
  endtask

  initial begin
    fb_if.fb_data = '0;
    fill_random();
    test_reset();
    test_timing();
    test_pattern();
    test_addr();
    test_segment();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
